// File: rtl/fetch_unit_pkg.sv
// Shared fetch types: FSM state encoding and the queue entry layout.
// The fault field exists only when FETCH_MISALIGN_CHECK_EN is defined.
package rvcpu;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        FETCH,
        DRAIN,
        HALTED
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
`ifdef FETCH_MISALIGN_CHECK_EN
        logic            fault;
`endif
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_queue.sv
// Registered FIFO of fetched entries (no bypass); flush empties it, and a push
// in the flush cycle becomes the sole surviving entry.
module fetch_queue
    import rvcpu::*;
#(
    parameter int unsigned Depth   = 2,
    parameter type         entry_t = fetch_entry_t
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  entry_t                 push_data_i,
    input  logic                   pop_i,
    output entry_t                 head_o,
    output logic [$clog2(Depth):0] count_o
);
    localparam int unsigned AW = $clog2(Depth);
    localparam int unsigned CW = AW + 1;

    entry_t        mem_q [Depth];
    logic [AW-1:0] rd_q, wr_q, wr_idx;
    logic [CW-1:0] count_q;

    assign wr_idx  = flush_i ? '0 : wr_q;
    assign head_o  = mem_q[rd_q];
    assign count_o = count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            rd_q    <= '0;
            wr_q    <= AW'(push_i);
            count_q <= CW'(push_i);
        end else begin
            if (push_i) wr_q <= wr_q + AW'(1);
            if (pop_i)  rd_q <= rd_q + AW'(1);
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_idx] <= push_data_i;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: sequential pc requests, in-flight/kill tracking,
// halt/drain FSM and an in-order response queue. Option: FETCH_MISALIGN_CHECK_EN.
module fetch_unit
    import rvcpu::*;
#(
    parameter int unsigned      Width   = 32,
    parameter int unsigned      Depth   = 2,
    parameter logic [Width-1:0] ResetPc = '0
) (
    input  logic             clk,
    input  logic             reset,
    output logic             req_valid,
    input  logic             req_ready,
    output logic [Width-1:0] req_addr,
    input  logic             rsp_valid,
    input  logic [Width-1:0] rsp_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [Width-1:0] out_pc,
    output logic [Width-1:0] out_instr,
    input  logic             redirect_valid,
    input  logic [Width-1:0] redirect_pc,
    input  logic             halt_req,
`ifdef FETCH_MISALIGN_CHECK_EN
    output logic             out_fault,
`endif
    output logic             halted
);
    localparam int unsigned CW = $clog2(Depth) + 1;
    localparam int unsigned IW = CW + 1;

    fetch_state_t     state_q, state_d;
    logic [Width-1:0] pc_q, pc_d;
    logic [CW-1:0]    outst_q, outst_d;
    logic [CW-1:0]    kill_q, kill_d;
    logic [CW-1:0]    q_count;
    logic [IW-1:0]    inflight;
    logic             accept, pop, rsp_owned, rsp_live, misalign, push;
    logic [Width-1:0] target_pc, rsp_pc;
    fetch_entry_t     push_entry, head;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign misalign  = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign target_pc = redirect_pc;
`else
    assign misalign  = 1'b0;
    assign target_pc = redirect_pc & ~Width'(3);
`endif

    assign pop       = out_valid && out_ready;
    // A head popped this cycle frees its slot in time for a same-cycle issue.
    assign inflight  = IW'(outst_q) + IW'(q_count) - IW'(pop);
    assign req_valid = !reset && (state_q == FETCH) && !redirect_valid && !halt_req
                       && (inflight < IW'(Depth));
    assign req_addr  = pc_q;
    assign accept    = req_valid && req_ready;

    // Responses with nothing outstanding (left over from before a reset) are ignored.
    assign rsp_owned = rsp_valid && (outst_q != '0);
    assign rsp_live  = rsp_owned && (kill_q == '0) && !redirect_valid;
    // Once kills are retired, every outstanding request is sequential up to pc_q.
    assign rsp_pc    = pc_q - (Width'(outst_q) << 2);
    assign push      = rsp_live || misalign;

    always_comb begin
        push_entry       = '0;
        push_entry.pc    = rsp_pc;
        push_entry.instr = rsp_data;
`ifdef FETCH_MISALIGN_CHECK_EN
        if (misalign) begin
            push_entry.pc    = redirect_pc;
            push_entry.instr = '0;
            push_entry.fault = 1'b1;
        end
`endif
    end

    always_comb begin
        outst_d = outst_q + CW'(accept) - CW'(rsp_owned);
        pc_d    = accept ? pc_q + Width'(4) : pc_q;
        kill_d  = kill_q;
        state_d = state_q;
        if (rsp_owned && (kill_q != '0)) kill_d = kill_q - CW'(1);
        if (redirect_valid) begin
            pc_d    = target_pc;
            kill_d  = outst_q - CW'(rsp_owned);
            state_d = misalign ? HALTED : FETCH;
        end else begin
            case (state_q)
                FETCH:   if (halt_req) state_d = DRAIN;
                DRAIN:   if (outst_d == '0) state_d = HALTED;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= ResetPc;
            outst_q <= '0;
            kill_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            outst_q <= outst_d;
            kill_q  <= kill_d;
        end
    end

    fetch_queue #(
        .Depth   (Depth),
        .entry_t (fetch_entry_t)
    ) u_queue (
        .clk         (clk),
        .reset       (reset),
        .flush_i     (redirect_valid),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (q_count)
    );

    assign out_valid = !reset && (q_count != '0);
    assign out_pc    = head.pc;
    assign out_instr = head.instr;
`ifdef FETCH_MISALIGN_CHECK_EN
    assign out_fault = head.fault;
`endif
    assign halted    = !reset && (state_q == HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: vector table plus scoreboarded memory model.
module tb_fetch_unit;
    import rvcpu::*;

    localparam int unsigned W = 32;
    localparam int unsigned D = 2;

    logic          clk = 1'b0;
    logic          reset, req_valid, req_ready, rsp_valid, out_valid, out_ready;
    logic          redirect_valid, halt_req, halted;
    logic [W-1:0]  req_addr, rsp_data, out_pc, out_instr, redirect_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic          out_fault;
`endif

    always #5 clk = ~clk;

    fetch_unit #(.Width(W), .Depth(D), .ResetPc(32'h0)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
`ifdef FETCH_MISALIGN_CHECK_EN
        .out_fault      (out_fault),
`endif
        .halted         (halted)
    );

    typedef struct { logic [31:0] addr; int due; } pend_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; logic fault; } exp_t;
    typedef struct {
        logic        req_ready;
        logic        out_ready;
        logic        exp_req_valid;
        logic [31:0] exp_req_addr;
        logic        exp_out_valid;
        logic [31:0] exp_out_pc;
    } vec_t;

    pend_t       pend[$];
    exp_t        expq[$];
    vec_t        tbl[6];
    int          cyc, last_due, lat_lo, lat_hi, n_acc, nvec, nfail;
    logic [31:0] next_pc;
    logic        seen;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        nvec++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // First half of a cycle: memory drives its response, outputs settle.
    task automatic cyc_a();
        @(negedge clk);
        if (pend.size() != 0 && pend[0].due <= cyc) begin
            rsp_valid = 1'b1;
            rsp_data  = mem_word(pend[0].addr);
        end else begin
            rsp_valid = 1'b0;
            rsp_data  = '0;
        end
        #1;
    endtask

    // Second half: scoreboard the handshakes seen this cycle, then advance.
    task automatic cyc_b();
        exp_t e;
        int   d;
        if (reset) begin
            pend.delete();
            expq.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    nvec++;
                    nfail++;
                    $display("FAIL unexpected_out actual=%h required=none (cycle %0d)", out_pc, cyc);
                end else begin
                    e = expq.pop_front();
                    chk("out_pc", out_pc, e.pc);
`ifdef FETCH_MISALIGN_CHECK_EN
                    chk("out_fault", 32'(out_fault), 32'(e.fault));
`endif
                    if (!e.fault) chk("out_instr", out_instr, e.instr);
                end
            end
            if (rsp_valid) pend.delete(0);
            if (redirect_valid) begin
                expq.delete();
`ifdef FETCH_MISALIGN_CHECK_EN
                if (redirect_pc[1:0] != 2'b00) expq.push_back('{redirect_pc, 32'h0, 1'b1});
`endif
                next_pc = redirect_pc & ~32'h3;
            end
            if (req_valid && req_ready) begin
                chk("req_addr", req_addr, next_pc);
                n_acc++;
                d = cyc + int'($urandom_range(lat_hi, lat_lo));
                if (d <= last_due) d = last_due + 1;
                last_due = d;
                pend.push_back('{req_addr, d});
                expq.push_back('{next_pc, mem_word(next_pc), 1'b0});
                next_pc += 32'd4;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic cycle();
        cyc_a();
        cyc_b();
    endtask

    task automatic do_reset();
        reset = 1'b1; req_ready = 1'b0; out_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0; halt_req = 1'b0;
        cycle();
        cyc_a();
        chk("rst_req_valid", 32'(req_valid), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        cyc_b();
        reset = 1'b0; next_pc = 32'h0; last_due = cyc;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        nvec = 0; nfail = 0; cyc = 0; last_due = 0; n_acc = 0;
        lat_lo = 1; lat_hi = 1; next_pc = '0; seen = 1'b0;
        rsp_valid = 1'b0; rsp_data = '0;
        tbl[0] = '{1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h0};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h0};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h0};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h4};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h8};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 32'h14, 1'b1, 32'hC};

        // Streaming with a 1-cycle memory.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            req_ready = tbl[i].req_ready;
            out_ready = tbl[i].out_ready;
            cyc_a();
            chk("tbl_req_valid", 32'(req_valid), 32'(tbl[i].exp_req_valid));
            if (tbl[i].exp_req_valid) chk("tbl_req_addr", req_addr, tbl[i].exp_req_addr);
            chk("tbl_out_valid", 32'(out_valid), 32'(tbl[i].exp_out_valid));
            if (tbl[i].exp_out_valid) chk("tbl_out_pc", out_pc, tbl[i].exp_out_pc);
            cyc_b();
        end

        // Decode backpressure fills the queue, then releases it.
        do_reset();
        req_ready = 1'b1; out_ready = 1'b0; n_acc = 0;
        repeat (10) cycle();
        cyc_a();
        chk("bp_accepts", 32'(n_acc), 32'(D));
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        chk("bp_req_valid", 32'(req_valid), 32'd0);
        cyc_b();
        out_ready = 1'b1;
        repeat (12) cycle();

        // Redirect with two requests in flight.
        do_reset();
        lat_lo = 3; lat_hi = 3; req_ready = 1'b1; out_ready = 1'b1;
        cycle(); cycle();
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        cyc_a();
        chk("redir_req_valid", 32'(req_valid), 32'd0);
        cyc_b();
        redirect_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc_a();
            if (out_valid && !seen) begin
                chk("redir_first_pc", out_pc, 32'h100);
                seen = 1'b1;
            end
            cyc_b();
        end
        chk("redir_output_seen", 32'(seen), 32'd1);

        // Halt with one request in flight, then resume by redirect.
        do_reset();
        lat_lo = 2; lat_hi = 2; req_ready = 1'b1; out_ready = 1'b1;
        cycle();
        req_ready = 1'b0; halt_req = 1'b1;
        cyc_a();
        chk("halt_req_valid", 32'(req_valid), 32'd0);
        cyc_b();
        halt_req = 1'b0; req_ready = 1'b1;
        cyc_a();
        chk("drain_req_valid", 32'(req_valid), 32'd0);
        chk("drain_halted", 32'(halted), 32'd0);
        cyc_b();
        cyc_a();
        chk("halted_after_rsp", 32'(halted), 32'd1);
        chk("halt_out_valid", 32'(out_valid), 32'd1);
        chk("halt_out_pc", out_pc, 32'h0);
        cyc_b();
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        cyc_a();
        chk("halted_hold", 32'(halted), 32'd1);
        cyc_b();
        redirect_valid = 1'b0;
        cyc_a();
        chk("resume_req_valid", 32'(req_valid), 32'd1);
        chk("resume_req_addr", req_addr, 32'h40);
        chk("resume_halted", 32'(halted), 32'd0);
        cyc_b();
        repeat (8) cycle();

        // Random request backpressure and memory latency.
        do_reset();
        lat_lo = 1; lat_hi = 4;
        for (int i = 0; i < 300; i++) begin
            req_ready = ($urandom_range(1, 0) != 0);
            out_ready = ($urandom_range(3, 0) != 0);
            cycle();
        end
        req_ready = 1'b1; out_ready = 1'b1; halt_req = 1'b1;
        cycle();
        halt_req = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            cyc_a();
            if (halted) seen = 1'b1;
            cyc_b();
        end
        chk("rand_halts", 32'(seen), 32'd1);
        repeat (D + 2) cycle();
        chk("rand_drained", 32'(expq.size()), 32'd0);

        // Redirect to a non-word-aligned target.
        out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h102;
        cycle();
        redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        cyc_a();
        chk("fault_out_valid", 32'(out_valid), 32'd1);
        chk("fault_flag", 32'(out_fault), 32'd1);
        chk("fault_out_pc", out_pc, 32'h102);
        chk("fault_req_valid", 32'(req_valid), 32'd0);
        chk("fault_halted", 32'(halted), 32'd1);
        cyc_b();
        repeat (3) cycle();
        out_ready = 1'b1;
        cycle();
        cyc_a();
        chk("fault_single_entry", 32'(out_valid), 32'd0);
        chk("fault_still_halted", 32'(halted), 32'd1);
        cyc_b();
`else
        out_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc_a();
            if (req_valid && !seen) begin
                chk("align_req_addr", req_addr, 32'h100);
                seen = 1'b1;
            end
            cyc_b();
        end
        chk("align_req_seen", 32'(seen), 32'd1);
`endif

        // Reset in the middle of traffic abandons everything in flight.
        lat_lo = 3; lat_hi = 4; req_ready = 1'b1; out_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        cycle();
        redirect_valid = 1'b0;
        repeat (6) cycle();
        do_reset();
        lat_lo = 1; lat_hi = 1; req_ready = 1'b1; out_ready = 1'b1;
        cyc_a();
        chk("post_rst_req_valid", 32'(req_valid), 32'd1);
        chk("post_rst_req_addr", req_addr, 32'h0);
        cyc_b();
        repeat (8) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter Width, 32, datapath and address width in bits.
REQ-002 Parameter Depth, 2, queue entries and maximum outstanding memory requests (power of two, >=2).
REQ-003 Parameter ResetPc, 'h0, first fetch address after reset.
REQ-004 Clocking and reset: one clock `clk`; `reset` synchronous, active-high.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 req_valid  output  1  instruction-memory read request valid.
REQ-008 req_ready  input  1  memory accepts request this cycle.
REQ-009 req_addr  output  Width  request byte address (pc).
REQ-010 rsp_valid  input  1  read data valid; in request order, >=1 cycle after acceptance.
REQ-011 rsp_data  input  Width  instruction word.
REQ-012 out_valid  output  1  queue head holds an instruction for decode.
REQ-013 out_ready  input  1  decode consumes head this cycle.
REQ-014 out_pc  output  Width  address of head instruction.
REQ-015 out_instr  output  Width  head instruction word.
REQ-016 redirect_valid  input  1  branch/jump redirect.
REQ-017 redirect_pc  input  Width  redirect target.
REQ-018 halt_req  input  1  stop fetching (wfi).
REQ-019 halted  output  1  fetch stopped, nothing in flight.

Function
REQ-020 Request issued when state FETCH and outstanding + queue count < Depth; accepted on req_valid && req_ready; pc += 4 on acceptance.
REQ-021 req_valid and req_addr held stable until accepted unless redirect or halt occurs.
REQ-022 Outstanding counter: +1 on acceptance, -1 on rsp_valid; both in same cycle leave it unchanged.
REQ-023 Non-killed response written to queue with pc of its request; queue is FIFO; head popped on out_valid && out_ready.
REQ-024 Response to queue-head output latency minimum 1 cycle (registered queue; no bypass).
REQ-025 Simultaneous push and pop with queue full: legal; occupancy unchanged.
REQ-026 Redirect: queue flushed, pc <= redirect_pc, kill count <= outstanding - rsp_valid, no request issued that cycle; issue resumes the next cycle.
REQ-027 Responses arriving while kill count > 0 are discarded and decrement it; redirect during nonzero kill count recomputes per REQ-026.
REQ-028 States: FETCH -> DRAIN on halt_req; DRAIN -> HALTED when outstanding == 0; HALTED -> FETCH on redirect_valid; redirect in DRAIN -> FETCH.
REQ-029 In DRAIN/HALTED, req_valid = 0; live responses still enqueued; halted = 1 only in HALTED.
REQ-030 redirect_valid has priority over halt_req in the same cycle.
REQ-031 pc wraps modulo 2^Width.

Reset
REQ-032 On reset: state FETCH, pc = ResetPc, queue empty, outstanding = 0, kill count = 0.
REQ-033 During reset cycle outputs: req_valid = 0, out_valid = 0, halted = 0; first request in the first cycle after reset deasserts.
REQ-034 Reset mid-operation abandons in-flight requests; responses in the cycle after reset are discarded (environment must not rely on them).

Configuration
REQ-035 Macro FETCH_MISALIGN_CHECK_EN: when defined, a redirect_pc with [1:0] != 0 produces output out_fault (1 bit, valid with out_valid) as a single queue entry carrying redirect_pc, no memory request issued, state -> HALTED until the next redirect.
REQ-036 Without FETCH_MISALIGN_CHECK_EN: no out_fault port; redirect_pc[1:0] ignored (treated as 0).

Structure
REQ-037 Package rvcpu holds fetch_state_t enum (FETCH, DRAIN, HALTED) and fetch_entry_t struct (pc, instr, fault when enabled).
REQ-038 Queue is sub-module fetch_queue (parameterised Depth, entry type fetch_entry_t, with flush input); fetch_unit holds pc, counters, FSM.

Verification
REQ-039 Reset, req_ready = 1, 1-cycle memory, out_ready = 1 -> out_pc 0,4,8,12 on consecutive cycles after 2-cycle fill.
REQ-040 out_ready = 0 for 10 cycles -> exactly Depth requests accepted, queue full, req_valid = 0; release -> order preserved, no loss.
REQ-041 Redirect to 'h100 with 2 outstanding -> both responses dropped, next out_pc = 'h100.
REQ-042 halt_req with 1 outstanding -> DRAIN, response enqueued, halted = 1 one cycle after it; redirect to 'h40 -> FETCH, req_addr = 'h40.
REQ-043 req_ready random 50%, memory latency random 1-4 -> out_pc strictly +4 sequence, out_instr matches memory model.
REQ-044 With FETCH_MISALIGN_CHECK_EN: redirect to 'h102 -> one entry out_fault = 1 out_pc = 'h102, no request, halted = 1.
